// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types and constants for the calculator ALU sequencing controller.
package alu_seq_ctrl_pkg;

    localparam int unsigned RESULT_W = 16;
    localparam int unsigned OP_W     = 2;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GET_B = 2'b01,
        S_EXEC  = 2'b10,
        S_SHOW  = 2'b11
    } state_e;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef struct packed {
        logic div;
        logic mul;
        logic sub;
        logic add;
    } sel_t;

    function automatic sel_t decode_op(input op_e op);
        sel_t s;
        s = '0;
        case (op)
            OP_ADD: s.add = 1'b1;
            OP_SUB: s.sub = 1'b1;
            OP_MUL: s.mul = 1'b1;
            OP_DIV: s.div = 1'b1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Button/switch inputs, ALU feedback and datapath control outputs of the sequencer.
interface alu_seq_ctrl_if;
    import alu_seq_ctrl_pkg::*;

    logic                btn_enter;
    logic [OP_W-1:0]     op;
    logic [RESULT_W-1:0] alu_result;
    logic                alu_status;
    logic                load_a;
    logic                load_b;
    logic                sel_add;
    logic                sel_sub;
    logic                sel_mul;
    logic                sel_div;
    logic [RESULT_W-1:0] result_out;
    logic                flag_out;
    logic                busy;
    logic                done;
    logic [1:0]          state_out;

    modport master (
        input  btn_enter, op, alu_result, alu_status,
        output load_a, load_b, sel_add, sel_sub, sel_mul, sel_div,
               result_out, flag_out, busy, done, state_out
    );

    modport slave (
        output btn_enter, op, alu_result, alu_status,
        input  load_a, load_b, sel_add, sel_sub, sel_mul, sel_div,
               result_out, flag_out, busy, done, state_out
    );

endinterface

// File: rtl/alu_seq_ctrl_btn_cond.sv
// Enter-button conditioning: 2-flop synchroniser, optional debounce, one-cycle press pulse.
// Build option: ALU_SEQ_DEBOUNCE_EN adds the DEBOUNCE_CYCLES stability filter.
module alu_seq_ctrl_btn_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    if (DEBOUNCE_CYCLES < 1) begin : g_db_range
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic press_q, press_d;
    logic level;

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            filt_q, filt_d;

    // Filtered level follows the synchronised level only after DEBOUNCE_CYCLES equal samples
    always_comb begin
        db_cnt_d = db_cnt_q;
        filt_d   = filt_q;
        if (sync2_q == filt_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            filt_d   = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q <= '0;
            filt_q   <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            filt_q   <= filt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        prev_d  = level;
        press_d = level & ~prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Enter-button sequencer for the 8-bit calculator: load A -> load B -> execute -> show.
// Build option: ALU_SEQ_DEBOUNCE_EN enables button debouncing in the conditioning block.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_ctrl_if.master bus
);

    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 255) begin : g_exec_range
        $error("EXEC_CYCLES must be in 1..255");
    end

    logic press;

    alu_seq_ctrl_btn_cond #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_cond (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(bus.btn_enter),
        .press  (press)
    );

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                load_a_q, load_a_d;
    logic                load_b_q, load_b_d;
    sel_t                sel_q, sel_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                flag_q, flag_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Next state plus next value of every registered output
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        load_a_d = 1'b0;
        load_b_d = 1'b0;
        result_d = result_q;
        flag_d   = flag_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE, S_SHOW: begin
                if (press) begin
                    load_a_d = 1'b1;
                    state_d  = S_GET_B;
                end
            end
            S_GET_B: begin
                // Stay here while load_b pulses so the strobe never overlaps S_EXEC
                if (load_b_q) begin
                    state_d = S_EXEC;
                end else if (press) begin
                    load_b_d = 1'b1;
                    op_d     = op_e'(bus.op);
                    cnt_d    = CNT_W'(EXEC_CYCLES - 1);
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    result_d = bus.alu_result;
                    flag_d   = bus.alu_status;
                    done_d   = 1'b1;
                    state_d  = S_SHOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase

        busy_d = (state_d == S_EXEC);
        sel_d  = (state_d == S_EXEC || state_d == S_SHOW) ? decode_op(op_d) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            load_a_q <= 1'b0;
            load_b_q <= 1'b0;
            sel_q    <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            load_a_q <= load_a_d;
            load_b_q <= load_b_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.load_a     = load_a_q;
    assign bus.load_b     = load_b_q;
    assign bus.sel_add    = sel_q.add;
    assign bus.sel_sub    = sel_q.sub;
    assign bus.sel_mul    = sel_q.mul;
    assign bus.sel_div    = sel_q.div;
    assign bus.result_out = result_q;
    assign bus.flag_out   = flag_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.state_out  = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: table of calculator operations plus corner-case sequences.
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    localparam int unsigned EXEC = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int DB = 16;
`else
    localparam int DB = 0;
`endif
    localparam int PRESS_LAT = 4 + DB;
    localparam int HOLD      = (DB == 0) ? 3 : DB + 4;
    localparam int GAP       = DB + 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl #(
        .EXEC_CYCLES    (EXEC),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Stand-in datapath: A/B registers and a combinational ALU driven by the DUT selects
    logic [7:0]  sw, a_reg, b_reg;
    logic [15:0] aw, bw, alu_r;
    logic        alu_s;

    always_ff @(posedge clk) begin
        if (bus.load_a) a_reg <= sw;
        if (bus.load_b) b_reg <= sw;
    end

    always_comb begin
        aw    = {8'h00, a_reg};
        bw    = {8'h00, b_reg};
        alu_r = 16'h0000;
        alu_s = 1'b0;
        if (bus.sel_add)      alu_r = aw + bw;
        else if (bus.sel_sub) alu_r = aw - bw;
        else if (bus.sel_mul) alu_r = aw * bw;
        else if (bus.sel_div) alu_r = (bw == 16'h0000) ? 16'hFFFF : aw / bw;
        if (bus.sel_add | bus.sel_sub | bus.sel_mul | bus.sel_div)
            alu_s = (alu_r == 16'h0000) || (bus.sel_div && bw == 16'h0000);
        bus.alu_result = alu_r;
        bus.alu_status = alu_s;
    end

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        flag;
    } vec_t;

    typedef struct packed {
        logic [15:0] res;
        logic        flag;
    } exp_t;

    vec_t        vt [8];
    exp_t        exp_q [$];
    exp_t        e;
    logic [15:0] hold_res;
    logic        hold_flag;
    logic [3:0]  exp_sel;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_la = 0;
    int          n_lb = 0;
    int          n_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.load_a;
            1:       return bus.load_b;
            default: return bus.done;
        endcase
    endfunction

    // Continuous checks and scoreboard pop on every done pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.load_a) n_la++;
            if (bus.load_b) n_lb++;
            chk("load_exclusive", 32'(bus.load_a & bus.load_b), 32'd0);
            chk("no_load_in_exec", 32'((bus.load_a | bus.load_b) & bus.busy), 32'd0);
            chk("busy_vs_state", 32'(bus.busy), 32'(bus.state_out == 2'b10));
            chk("sel_onehot", 32'({bus.sel_div, bus.sel_mul, bus.sel_sub, bus.sel_add}),
                32'(bus.state_out[1] ? exp_sel : 4'b0000));
            if (bus.done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL done_unexpected: done pulse with empty scoreboard at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_out", 32'(bus.result_out), 32'(e.res));
                    chk("flag_out", 32'(bus.flag_out), 32'(e.flag));
                    hold_res  = e.res;
                    hold_flag = e.flag;
                end
            end else begin
                chk("result_held", 32'(bus.result_out), 32'(hold_res));
                chk("flag_held", 32'(bus.flag_out), 32'(hold_flag));
            end
        end
    end

    task automatic check_zero(input string name);
        chk({name, "_load_a"}, 32'(bus.load_a), 32'd0);
        chk({name, "_load_b"}, 32'(bus.load_b), 32'd0);
        chk({name, "_sel"}, 32'({bus.sel_div, bus.sel_mul, bus.sel_sub, bus.sel_add}), 32'd0);
        chk({name, "_result"}, 32'(bus.result_out), 32'd0);
        chk({name, "_flag"}, 32'(bus.flag_out), 32'd0);
        chk({name, "_busy"}, 32'(bus.busy), 32'd0);
        chk({name, "_done"}, 32'(bus.done), 32'd0);
        chk({name, "_state"}, 32'(bus.state_out), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        hold_res  = 16'h0000;
        hold_flag = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Raise the button and wait (bounded) for the selected strobe; lat = negedges until it appears
    task automatic press_wait(input int which, input int hold, input int budget,
                              input string name, output int lat);
        lat = -1;
        bus.btn_enter = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == hold) bus.btn_enter = 1'b0;
            if (lat < 0 && sig(which)) lat = c;
            if (c >= hold && lat >= 0) break;
        end
        bus.btn_enter = 1'b0;
        if (lat < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no strobe within %0d cycles", name, budget);
        end
    endtask

    task automatic do_a(input vec_t v);
        int lat;
        repeat (GAP) @(negedge clk);
        sw = v.a;
        press_wait(0, HOLD, 80, "load_a_wait", lat);
        if (lat >= 0) begin
            chk("load_a_latency", 32'(lat), 32'(PRESS_LAT));
            chk("state_at_load_a", 32'(bus.state_out), 32'(S_GET_B));
        end
    endtask

    // mode 0: normal; 1: extra press during S_EXEC; 2: async reset at counter==2
    task automatic do_b(input vec_t v, input int mode);
        int lat, nb, dl, la0, lb0, d0;
        bit got;
        repeat (GAP) @(negedge clk);
        sw      = v.b;
        bus.op  = v.op;
        exp_sel = 4'b0001 << v.op;
        exp_q.push_back('{res: v.res, flag: v.flag});
        press_wait(1, HOLD, 80, "load_b_wait", lat);
        if (lat < 0) return;
        chk("load_b_latency", 32'(lat), 32'(PRESS_LAT));
        chk("state_at_load_b", 32'(bus.state_out), 32'(S_GET_B));
        bus.op = ~v.op;
        #1;
        la0 = n_la;
        lb0 = n_lb;
        nb  = 0;
        dl  = 0;
        got = 1'b0;
        for (int c = 1; c <= int'(EXEC) + 10; c++) begin
            @(negedge clk);
            if (mode == 1) begin
                if (c == 1) bus.btn_enter = 1'b1;
                if (c == 3) bus.btn_enter = 1'b0;
            end
            if (bus.busy) nb++;
            if (mode == 2 && nb == 2) begin
                #2 rst = 1'b1;
                #1 check_zero("rst_mid_exec");
                exp_q.delete();
                hold_res  = 16'h0000;
                hold_flag = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                #1 d0 = n_done;
                repeat (int'(EXEC) + 8) @(negedge clk);
                #1;
                chk("no_done_after_rst", 32'(n_done - d0), 32'd0);
                chk("idle_after_rst", 32'(bus.state_out), 32'(S_IDLE));
                return;
            end
            if (bus.done) begin
                got = 1'b1;
                dl  = c;
                break;
            end
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_wait: no done pulse within %0d cycles", EXEC + 10);
            return;
        end
        chk("busy_cycles", 32'(nb), 32'(EXEC));
        chk("done_latency", 32'(dl), 32'(EXEC + 1));
        chk("state_at_done", 32'(bus.state_out), 32'(S_SHOW));
        #1 chk("no_load_in_exec_count", 32'((n_la - la0) + (n_lb - lb0)), 32'd0);
        if (mode == 1) begin
            repeat (GAP) @(negedge clk);
            #1;
            chk("exec_press_ignored", 32'(n_la - la0), 32'd0);
            chk("still_show", 32'(bus.state_out), 32'(S_SHOW));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int la0, lb0;
        vt[0] = '{op: 2'b00, a: 8'h10, b: 8'h20, res: 16'h0030, flag: 1'b0};
        vt[1] = '{op: 2'b10, a: 8'h0C, b: 8'h0D, res: 16'h009C, flag: 1'b0};
        vt[2] = '{op: 2'b01, a: 8'h05, b: 8'h07, res: 16'hFFFE, flag: 1'b0};
        vt[3] = '{op: 2'b11, a: 8'hC8, b: 8'h0A, res: 16'h0014, flag: 1'b0};
        vt[4] = '{op: 2'b01, a: 8'h33, b: 8'h33, res: 16'h0000, flag: 1'b1};
        vt[5] = '{op: 2'b10, a: 8'hFF, b: 8'hFF, res: 16'hFE01, flag: 1'b0};
        vt[6] = '{op: 2'b11, a: 8'h07, b: 8'h00, res: 16'hFFFF, flag: 1'b1};
        vt[7] = '{op: 2'b00, a: 8'hFF, b: 8'h01, res: 16'h0100, flag: 1'b0};

        rst           = 1'b1;
        bus.btn_enter = 1'b0;
        bus.op        = 2'b00;
        sw            = 8'h00;
        hold_res      = 16'h0000;
        hold_flag     = 1'b0;
        exp_sel       = 4'b0000;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

`ifdef ALU_SEQ_DEBOUNCE_EN
        // Short glitch must be filtered out
        repeat (GAP) @(negedge clk);
        bus.btn_enter = 1'b1;
        repeat (5) @(negedge clk);
        bus.btn_enter = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("glitch_no_press", 32'(n_la), 32'd0);
        chk("glitch_state", 32'(bus.state_out), 32'(S_IDLE));
`endif

        for (int i = 0; i < 8; i++) begin
            do_a(vt[i]);
            do_b(vt[i], 0);
        end

        // Held button from idle yields exactly one press
        do_reset();
        repeat (GAP) @(negedge clk);
        #1;
        la0 = n_la;
        lb0 = n_lb;
        sw  = vt[0].a;
        bus.btn_enter = 1'b1;
        repeat (50) @(negedge clk);
        bus.btn_enter = 1'b0;
        repeat (GAP) @(negedge clk);
        #1;
        chk("held_one_load_a", 32'(n_la - la0), 32'd1);
        chk("held_no_load_b", 32'(n_lb - lb0), 32'd0);
        chk("held_state", 32'(bus.state_out), 32'(S_GET_B));
        do_b(vt[0], 0);

`ifndef ALU_SEQ_DEBOUNCE_EN
        do_a(vt[1]);
        do_b(vt[1], 1);
`endif
        do_a(vt[2]);
        do_b(vt[2], 0);

        do_a(vt[3]);
        do_b(vt[3], 2);

        do_a(vt[5]);
        do_b(vt[5], 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
